// File: rtl/tinker_mem_pkg.sv
// tinker_mem_pkg: shared types and defaults for the tinker memory responder.
//   mem_state_t  - responder FSM states (IDLE, WAIT, RESP)
//   mem_port_t   - which request channel owns the in-flight request
//   mem_req_t    - latched request record (port, addr, write, wdata)
//   is_misaligned - natural-alignment test used when TINKER_MEM_ALIGN_CHECK_EN is defined
package tinker_mem_pkg;

    localparam int MEM_BYTES_DEFAULT = 524288;
    localparam int LATENCY_DEFAULT   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } mem_port_t;

    typedef struct packed {
        mem_port_t   port;
        logic [63:0] addr;
        logic        write;
        logic [63:0] wdata;
    } mem_req_t;

    // Fetches are 32-bit words, data accesses are 64-bit doublewords.
    function automatic logic is_misaligned(input mem_port_t port, input logic [63:0] addr);
        logic mis;
        if (port == PORT_IF) begin
            mis = (addr[1:0] != 2'b00);
        end else begin
            mis = (addr[2:0] != 3'b000);
        end
        return mis;
    endfunction

endpackage

// File: rtl/tinker_mem_responder_if.sv
// tinker_mem_responder_if: fetch and data request/response channels between
// the tinker core (master) and the memory responder (slave).
//   if_req_*  - instruction-fetch request (valid/ready, 64-bit byte address)
//   if_rsp_*  - one-cycle fetch response pulse with 32-bit word and error flag
//   d_req_*   - data request (valid/ready, write flag, address, store data)
//   d_rsp_*   - one-cycle data response pulse with load data and error flag
interface tinker_mem_responder_if;

    logic        if_req_valid;
    logic        if_req_ready;
    logic [63:0] if_req_addr;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        if_rsp_err;

    logic        d_req_valid;
    logic        d_req_ready;
    logic        d_req_write;
    logic [63:0] d_req_addr;
    logic [63:0] d_req_wdata;
    logic        d_rsp_valid;
    logic [63:0] d_rsp_rdata;
    logic        d_rsp_err;

    modport master (
        output if_req_valid, if_req_addr,
        input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
        output d_req_valid, d_req_write, d_req_addr, d_req_wdata,
        input  d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err
    );

    modport slave (
        input  if_req_valid, if_req_addr,
        output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
        input  d_req_valid, d_req_write, d_req_addr, d_req_wdata,
        output d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err
    );

endinterface

// File: rtl/tinker_mem_array.sv
// tinker_mem_array: byte-addressed little-endian store.
//   clock, reset - clock and synchronous active-high reset (read register only)
//   rd_en        - register the 8 bytes at addr into rdata; rdata reads 0 otherwise
//   wr_en        - write all 8 bytes of wdata starting at addr
//   addr         - byte index; byte k of an access uses (addr + k) mod MEM_BYTES
//   rdata        - registered 64-bit little-endian read data
// The storage itself is never cleared by reset.
module tinker_mem_array
    import tinker_mem_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEFAULT,
    parameter int AW        = $clog2(MEM_BYTES)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          rd_en,
    input  logic          wr_en,
    input  logic [AW-1:0] addr,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);

    logic [7:0]  mem_r [MEM_BYTES];
    logic [63:0] rdata_r;

    // Byte writes; the AW-bit index sum wraps across the top of memory.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int k = 0; k < 8; k++) begin
                mem_r[addr + AW'(k)] <= wdata[8*k +: 8];
            end
        end
    end

    // Registered read; cleared whenever no read is requested so stores and
    // errored accesses return zero data.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_r <= 64'd0;
        end else if (rd_en) begin
            for (int k = 0; k < 8; k++) begin
                rdata_r[8*k +: 8] <= mem_r[addr + AW'(k)];
            end
        end else begin
            rdata_r <= 64'd0;
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/tinker_mem_responder.sv
// tinker_mem_responder: multi-cycle memory responder for the tinker core.
//   clock  - sole clock, rising edge
//   reset  - synchronous, active-high; drops any in-flight request
//   bus    - tinker_mem_responder_if.slave: fetch and data request/response channels
// Parameters: MEM_BYTES (power of two), LATENCY (1..15 cycles accept-to-response).
// One request in flight at a time; data has fixed priority over fetch.
// Define TINKER_MEM_ALIGN_CHECK_EN to turn misaligned accesses into error
// responses with no array access; otherwise they are served bytewise with wrap.
module tinker_mem_responder
    import tinker_mem_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEFAULT,
    parameter int LATENCY   = LATENCY_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    tinker_mem_responder_if.slave bus
);

    localparam int         AW       = $clog2(MEM_BYTES);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    mem_state_t  state_r;
    mem_state_t  state_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_s;
    mem_req_t    req_r;
    mem_req_t    new_req_s;
    mem_req_t    cur_req_s;
    logic        accept_s;
    logic        done_s;
    logic        err_s;
    logic        rd_en_s;
    logic        wr_en_s;
    logic [63:0] rdata_s;
    logic        if_rsp_valid_r;
    logic        d_rsp_valid_r;
    logic        if_rsp_err_r;
    logic        d_rsp_err_r;
    logic        unused_addr_s;

    // Candidate request for this cycle: data wins over fetch.
    always_comb begin
        new_req_s = '0;
        if (bus.d_req_valid) begin
            new_req_s.port  = PORT_D;
            new_req_s.addr  = bus.d_req_addr;
            new_req_s.write = bus.d_req_write;
            new_req_s.wdata = bus.d_req_wdata;
        end else begin
            new_req_s.port  = PORT_IF;
            new_req_s.addr  = bus.if_req_addr;
            new_req_s.write = 1'b0;
            new_req_s.wdata = 64'd0;
        end
    end

    assign accept_s = (state_r == IDLE) && (bus.d_req_valid || bus.if_req_valid);

    // With LATENCY==1 the array access happens on the accept edge itself, so
    // the live request is used in IDLE and the latched one afterwards.
    assign cur_req_s = (state_r == IDLE) ? new_req_s : req_r;

    // Next-state and latency counter. done_s marks the edge that enters RESP,
    // which is also the edge that commits stores and registers load data.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (LATENCY == 1) begin
                        state_s = RESP;
                        cnt_s   = 4'd0;
                        done_s  = 1'b1;
                    end else begin
                        state_s = WAIT;
                        cnt_s   = CNT_LOAD;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r <= 4'd1) begin
                    state_s = RESP;
                    cnt_s   = 4'd0;
                    done_s  = 1'b1;
                end else begin
                    state_s = WAIT;
                    cnt_s   = cnt_r - 4'd1;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

`ifdef TINKER_MEM_ALIGN_CHECK_EN
    assign err_s = is_misaligned(cur_req_s.port, cur_req_s.addr);
`else
    assign err_s = 1'b0;
`endif

    // Reset on the commit edge must suppress the store.
    assign rd_en_s = done_s && !reset && !cur_req_s.write && !err_s;
    assign wr_en_s = done_s && !reset &&  cur_req_s.write && !err_s;

    // Address bits above the array size are ignored.
    assign unused_addr_s = ^cur_req_s.addr[63:AW];

    tinker_mem_array #(
        .MEM_BYTES (MEM_BYTES),
        .AW        (AW)
    ) u_array (
        .clock (clock),
        .reset (reset),
        .rd_en (rd_en_s),
        .wr_en (wr_en_s),
        .addr  (cur_req_s.addr[AW-1:0]),
        .wdata (cur_req_s.wdata),
        .rdata (rdata_s)
    );

    // State, counter, request latch and response pulse registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= IDLE;
            cnt_r          <= 4'd0;
            req_r          <= '0;
            if_rsp_valid_r <= 1'b0;
            d_rsp_valid_r  <= 1'b0;
            if_rsp_err_r   <= 1'b0;
            d_rsp_err_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (accept_s) begin
                req_r <= new_req_s;
            end
            if_rsp_valid_r <= done_s && (cur_req_s.port == PORT_IF);
            d_rsp_valid_r  <= done_s && (cur_req_s.port == PORT_D);
            if_rsp_err_r   <= done_s && (cur_req_s.port == PORT_IF) && err_s;
            d_rsp_err_r    <= done_s && (cur_req_s.port == PORT_D) && err_s;
        end
    end

    assign bus.d_req_ready  = (state_r == IDLE);
    assign bus.if_req_ready = (state_r == IDLE) && !bus.d_req_valid;

    // Read data is zero outside load responses; steer it to the owning port.
    assign bus.if_rsp_valid = if_rsp_valid_r;
    assign bus.if_rsp_data  = if_rsp_valid_r ? rdata_s[31:0] : 32'd0;
    assign bus.if_rsp_err   = if_rsp_err_r;
    assign bus.d_rsp_valid  = d_rsp_valid_r;
    assign bus.d_rsp_rdata  = d_rsp_valid_r ? rdata_s : 64'd0;
    assign bus.d_rsp_err    = d_rsp_err_r;

endmodule
